// File: rtl/weight_medium.sv
// weight_medium: memory-side responder for the CPU weight port.
// Each W_SIZE-bit weight word is stored as BEATS consecutive BRAM lines,
// with beat 0 holding the least significant bits. Reads and writes run one
// at a time. finished_out is high whenever the block is idle.
// Optional feature (macro WEIGHT_MEDIUM_LAST_WORD_CACHE_EN): a one-entry
// cache of the last word read or written. A read that hits the cache
// finishes in one cycle and makes no BRAM access.
// Handshake: read_enable_in / write_enable_in are single-cycle request
// pulses. They are accepted only on an edge where the block is idle
// (finished_out high); pulses at any other time are dropped.
module weight_medium #(
  parameter int WEIGHT_LENGTH = 256,
  parameter int W_SIZE        = 1024,
  parameter int BRAM_WIDTH    = 64,
  parameter int READ_LATENCY  = 2,
  localparam int BEATS = W_SIZE / BRAM_WIDTH,
  localparam int PW    = $clog2(WEIGHT_LENGTH),
  localparam int AW    = $clog2(WEIGHT_LENGTH * BEATS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [PW-1:0]         pointer_in,
  input  logic [W_SIZE-1:0]     weight_in,
  output logic [W_SIZE-1:0]     weight_out,
  input  logic                  read_enable_in,
  input  logic                  write_enable_in,
  output logic                  finished_out,
  output logic [AW-1:0]         bram_addr_out,
  output logic [BRAM_WIDTH-1:0] bram_din_out,
  input  logic [BRAM_WIDTH-1:0] bram_dout_in,
  output logic                  bram_en_out,
  output logic                  bram_we_out,
  output logic [1:0]            state_dbg_out
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW-1:0] BEATS_A   = AW'(BEATS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           base_q, base_d;
  logic [W_SIZE-1:0]       word_q, word_d;
  logic [W_SIZE-1:0]       asm_q, asm_d;
  logic [W_SIZE-1:0]       weight_q, weight_d;
  logic [BW-1:0]           beat_q, beat_d, beat_nxt;
  logic [BW-1:0]           ret_q, ret_d;
  logic                    quick_q, quick_d;
  logic                    finished_q, finished_d;
  logic                    en_q, en_d, we_q, we_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [BRAM_WIDTH-1:0]   din_q, din_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [AW-1:0]           base_calc;
  logic                    ptr_oob;
  logic                    cache_hit;
  logic [W_SIZE-1:0]       cache_word;

  assign base_calc = AW'(pointer_in) * BEATS_A;

  // Pointers past the end only exist when WEIGHT_LENGTH is not a power of two.
  if (WEIGHT_LENGTH == (1 << PW)) begin : g_pow2
    assign ptr_oob = 1'b0;
  end else begin : g_npow2
    localparam logic [PW:0] WL_C = WEIGHT_LENGTH[PW:0];
    assign ptr_oob = ({1'b0, pointer_in} >= WL_C);
  end

`ifdef WEIGHT_MEDIUM_LAST_WORD_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [PW-1:0]     cache_ptr_q, cache_ptr_d;
  logic [W_SIZE-1:0] cache_data_q, cache_data_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  assign cache_hit  = cache_valid_q && (cache_ptr_q == pointer_in);
  assign cache_word = cache_data_q;

  // Cache entry and the pointer of the read in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cache_valid_q <= 1'b0;
      cache_ptr_q   <= '0;
      cache_data_q  <= '0;
      ptr_q         <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_ptr_q   <= cache_ptr_d;
      cache_data_q  <= cache_data_d;
      ptr_q         <= ptr_d;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      word_q     <= '0;
      asm_q      <= '0;
      weight_q   <= '0;
      beat_q     <= '0;
      ret_q      <= '0;
      quick_q    <= 1'b0;
      finished_q <= 1'b1;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rd_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_q     <= word_d;
      asm_q      <= asm_d;
      weight_q   <= weight_d;
      beat_q     <= beat_d;
      ret_q      <= ret_d;
      quick_q    <= quick_d;
      finished_q <= finished_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

  // Next state: accept requests, issue beats and collect the read returns.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_d     = word_q;
    asm_d      = asm_q;
    weight_d   = weight_q;
    beat_d     = beat_q;
    ret_d      = ret_q;
    quick_d    = quick_q;
    finished_d = finished_q;
    en_d       = en_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    beat_nxt   = beat_q + BW'(1);
    // Marks each read address on the bus; the mark reaches the end of the
    // pipe in the cycle that address's data is valid on bram_dout_in.
    rd_pipe_d  = rd_pipe_q;
    rd_pipe_d[0] = en_q & ~we_q;
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
`ifdef WEIGHT_MEDIUM_LAST_WORD_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_ptr_d   = cache_ptr_q;
    cache_data_d  = cache_data_q;
    ptr_d         = ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        finished_d = 1'b1;
        en_d       = 1'b0;
        we_d       = 1'b0;
        if (write_enable_in) begin
          state_d    = S_WRITE;
          finished_d = 1'b0;
          base_d     = base_calc;
          word_d     = weight_in;
          beat_d     = '0;
          quick_d    = ptr_oob;
          if (!ptr_oob) begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            addr_d = base_calc;
            din_d  = weight_in[BRAM_WIDTH-1:0];
`ifdef WEIGHT_MEDIUM_LAST_WORD_CACHE_EN
            cache_valid_d = 1'b1;
            cache_ptr_d   = pointer_in;
            cache_data_d  = weight_in;
`endif
          end
        end else if (read_enable_in) begin
          state_d    = S_READ;
          finished_d = 1'b0;
          base_d     = base_calc;
          beat_d     = '0;
          ret_d      = '0;
          quick_d    = ptr_oob | cache_hit;
          // A quick read delivers asm_q directly: zeros if out of range.
          asm_d      = (!ptr_oob && cache_hit) ? cache_word : '0;
`ifdef WEIGHT_MEDIUM_LAST_WORD_CACHE_EN
          ptr_d      = pointer_in;
`endif
          if (!(ptr_oob | cache_hit)) begin
            en_d   = 1'b1;
            we_d   = 1'b0;
            addr_d = base_calc;
          end
        end
      end

      S_WRITE: begin
        if (quick_q || beat_q == LAST_BEAT) begin
          state_d    = S_IDLE;
          finished_d = 1'b1;
          en_d       = 1'b0;
          we_d       = 1'b0;
        end else begin
          beat_d = beat_nxt;
          addr_d = base_q + AW'(beat_nxt);
          din_d  = word_q[int'(beat_nxt)*BRAM_WIDTH +: BRAM_WIDTH];
        end
      end

      S_READ: begin
        if (quick_q) begin
          state_d    = S_IDLE;
          finished_d = 1'b1;
          weight_d   = asm_q;
        end else begin
          if (en_q) begin
            if (beat_q == LAST_BEAT) begin
              en_d = 1'b0;
            end else begin
              beat_d = beat_nxt;
              addr_d = base_q + AW'(beat_nxt);
            end
          end
          if (rd_pipe_q[READ_LATENCY-1]) begin
            asm_d[int'(ret_q)*BRAM_WIDTH +: BRAM_WIDTH] = bram_dout_in;
            if (ret_q == LAST_BEAT) begin
              state_d    = S_IDLE;
              finished_d = 1'b1;
              weight_d   = asm_d;
`ifdef WEIGHT_MEDIUM_LAST_WORD_CACHE_EN
              cache_valid_d = 1'b1;
              cache_ptr_d   = ptr_q;
              cache_data_d  = asm_d;
`endif
            end else begin
              ret_d = ret_q + BW'(1);
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign weight_out    = weight_q;
  assign finished_out  = finished_q;
  assign bram_en_out   = en_q;
  assign bram_we_out   = we_q;
  assign bram_addr_out = addr_q;
  assign bram_din_out  = din_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_weight_medium.sv
// Directed bench for weight_medium: 16-bit words of four 4-bit beats,
// 12 words (so pointers 12..15 are out of range), read latency 2.
module tb_weight_medium;

`ifdef WEIGHT_MEDIUM_LAST_WORD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pointer = '0;
  logic [15:0] weight_in = '0;
  logic [15:0] weight_out;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic        finished;
  logic [5:0]  bram_addr;
  logic [3:0]  bram_din;
  logic [3:0]  bram_dout;
  logic        bram_en;
  logic        bram_we;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  // BRAM access record: {we, addr, din (0 for reads)}.
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  // Reference cache state (only consulted when the cache is built in).
  bit       m_valid = 1'b0;
  bit [3:0] m_ptr = '0;

  weight_medium #(
    .WEIGHT_LENGTH(12), .W_SIZE(16), .BRAM_WIDTH(4), .READ_LATENCY(2)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .pointer_in(pointer), .weight_in(weight_in),
    .weight_out(weight_out), .read_enable_in(read_en), .write_enable_in(write_en),
    .finished_out(finished), .bram_addr_out(bram_addr), .bram_din_out(bram_din),
    .bram_dout_in(bram_dout), .bram_en_out(bram_en), .bram_we_out(bram_we),
    .state_dbg_out(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Two-cycle synchronous BRAM model.
  logic [3:0] mem [64];
  logic [3:0] stage1 = '0;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bram_dout = '0;
  end
  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_din;
    stage1    <= mem[bram_addr];
    bram_dout <= stage1;
  end

  // Access monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bram_en) obs_q.push_back({bram_we, bram_addr, bram_we ? bram_din : 4'h0});
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_log(input string tag);
    logic [10:0] e, o;
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 11'bx;
      check({tag, ".access"}, o, e);
    end
  endtask

  task automatic exp_writes(input logic [5:0] base, input logic [15:0] w);
    logic [3:0] b[4];
    b[0] = w[3:0]; b[1] = w[7:4]; b[2] = w[11:8]; b[3] = w[15:12];
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, base + 6'(k), b[k]});
  endtask

  task automatic exp_reads(input logic [5:0] base);
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, base + 6'(k), 4'h0});
  endtask

  // Drive one request so it is sampled on edge E; returns at E + 1ns.
  task automatic start(input logic rd, input logic wr, input logic [3:0] ptr, input logic [15:0] data);
    @(negedge clk);
    read_en = rd; write_en = wr; pointer = ptr; weight_in = data;
    obs_q.delete();
    @(posedge clk);
    #1;
    read_en = 1'b0; write_en = 1'b0;
  endtask

  // Counts edges after E until finished_out is seen high (bounded).
  task automatic wait_done(inout int lat);
    while (finished !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_write(input string tag, input logic rd_too, input logic [3:0] ptr, input logic [15:0] w);
    int lat = 0;
    logic [15:0] prev_w = weight_out;
    bit oob = (ptr >= 4'd12);
    start(rd_too, 1'b1, ptr, w);
    check({tag, ".fin_low"}, finished, 0);
    wait_done(lat);
    check({tag, ".latency"}, lat, oob ? 1 : 4);
    check({tag, ".weight_kept"}, weight_out, prev_w);
    check({tag, ".en_idle"}, {bram_en, bram_we}, 2'b00);
    if (!oob) exp_writes(6'(ptr) * 6'd4, w);
    check_log(tag);
    if (!oob) begin m_valid = 1'b1; m_ptr = ptr; end
  endtask

  task automatic do_read(input string tag, input logic [3:0] ptr, input logic [15:0] exp_w);
    int lat = 0;
    bit oob = (ptr >= 4'd12);
    bit hit = CACHE && m_valid && (m_ptr == ptr) && !oob;
    start(1'b1, 1'b0, ptr, 16'h0);
    check({tag, ".fin_low"}, finished, 0);
    wait_done(lat);
    check({tag, ".latency"}, lat, (oob || hit) ? 1 : 6);
    check({tag, ".weight"}, weight_out, exp_w);
    if (!oob && !hit) exp_reads(6'(ptr) * 6'd4);
    check_log(tag);
    if (!oob) begin m_valid = 1'b1; m_ptr = ptr; end
  endtask

  initial begin
    int lat;
    // Reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.finished", finished, 1);
    check("reset.weight", weight_out, 16'h0);
    check("reset.en_we", {bram_en, bram_we}, 2'b00);
    check("reset.addr", bram_addr, 6'h0);
    check("reset.din", bram_din, 4'h0);
    check("reset.state", state_dbg, 2'd0);
    rst_n = 1'b1;

    // Write 16'hA5C3 to word 3: lines 12..15 get 3,C,5,A.
    do_write("wr3", 1'b0, 4'd3, 16'hA5C3);
    do_read("rd3", 4'd3, 16'hA5C3);

    // Both enables together: only the write happens.
    do_write("both1", 1'b1, 4'd1, 16'h1234);
    do_read("rd1", 4'd1, 16'h1234);

    // A second read pulse at E+2 is ignored.
    lat = 0;
    start(1'b1, 1'b0, 4'd3, 16'h0);
    @(posedge clk);
    @(negedge clk);
    read_en = 1'b1; pointer = 4'd5;
    @(posedge clk);
    #1;
    read_en = 1'b0;
    lat = 2;
    check("dup.state_busy", state_dbg, 2'd1);
    wait_done(lat);
    check("dup.latency", lat, 6);
    check("dup.weight", weight_out, 16'hA5C3);
    repeat (4) @(posedge clk);
    #1;
    check("dup.still_idle", finished, 1);
    exp_reads(6'd12);
    check_log("dup");
    m_valid = 1'b1; m_ptr = 4'd3;

    // Reset at E+2 of a write to word 2: only lines 8 and 9 are written.
    start(1'b0, 1'b1, 4'd2, 16'h9876);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid.we", bram_we, 0);
    check("rstmid.en", bram_en, 0);
    check("rstmid.finished", finished, 1);
    check("rstmid.weight", weight_out, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.push_back({1'b1, 6'd8, 4'h6});
    exp_q.push_back({1'b1, 6'd9, 4'h7});
    check_log("rstmid");
    do_read("rd2_partial", 4'd2, 16'h0076);

    // Out-of-range pointers: one-cycle completion, no BRAM traffic.
    do_read("rd_oob", 4'd13, 16'h0000);
    do_write("wr_oob", 1'b0, 4'd14, 16'hFFFF);

    // Write then read back-to-back (a cache hit when the cache is built in).
    do_write("wr7", 1'b0, 4'd7, 16'hBEEF);
    do_read("rd7", 4'd7, 16'hBEEF);
    do_read("rd3_again", 4'd3, 16'hA5C3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/weight_medium.md
Name: weight_medium

Overview:
- Memory-side responder for the CPU weight port. Serves single-word weight reads and writes requested through `weight_read_enable_out` / `weight_write_enable_out` and the pointer.
- Backs each W_SIZE-bit word with BEATS consecutive lines of a narrower synchronous BRAM. Sequences the beats and reports completion on `finished_out`.
- Sits between the control unit and the weight BRAM instance.

Parameters:
- WEIGHT_LENGTH, 256, number of W_SIZE-bit weight words.
- W_SIZE, 1024, weight word width in bits.
- BRAM_WIDTH, 64, BRAM data width; W_SIZE must be an integer multiple of it (BEATS = W_SIZE/BRAM_WIDTH).
- READ_LATENCY, 2, cycles from BRAM address/enable to valid `bram_dout_in` (must be ≥1).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- pointer_in  input  $clog2(WEIGHT_LENGTH)  word address from CPU
- weight_in  input  W_SIZE  write data from CPU
- weight_out  output  W_SIZE  read data to CPU
- read_enable_in  input  1  one-cycle read request pulse
- write_enable_in  input  1  one-cycle write request pulse
- finished_out  output  1  high when idle/complete
- bram_addr_out  output  $clog2(WEIGHT_LENGTH*BEATS)  BRAM line address
- bram_din_out  output  BRAM_WIDTH  BRAM write data
- bram_dout_in  input  BRAM_WIDTH  BRAM read data
- bram_en_out  output  1  BRAM port enable
- bram_we_out  output  1  BRAM write enable

Behaviour:
- Reset (rst_in==0 at an edge): state IDLE, `finished_out`=1, `weight_out`=0, `bram_en_out`=0, `bram_we_out`=0, `bram_addr_out`=0, `bram_din_out`=0, beat and return counters 0. Reset mid-operation aborts it; no further BRAM writes are issued; partial writes already committed are not rolled back.
- States: IDLE, READ, WRITE.
- IDLE: `finished_out`=1.
- At edge E where the block is IDLE and an enable is high:
  - latch `pointer_in` (and `weight_in` for a write);
  - base = pointer*BEATS;
  - `finished_out` goes 0 on that same edge E.
- Read/write both high at E: write wins; the read is dropped.
- Enables sampled while not IDLE are ignored; they do not queue.
- READ:
  - Cycles E+0..E+BEATS-1 (registered outputs after edge E+k): `bram_en_out`=1, `bram_we_out`=0, `bram_addr_out`=base+k.
  - Beat k returns on `bram_dout_in` READ_LATENCY cycles after its address. It is captured into bits [k*BRAM_WIDTH +: BRAM_WIDTH] of the assembly register; beat 0 is LSBs.
  - A return counter tracks captured beats. After the last capture, `weight_out` updates with the full word and `finished_out`=1 on the same edge E+BEATS+READ_LATENCY; state returns to IDLE.
  - `weight_out` is unchanged during READ and holds its value until the next completed read.
- WRITE:
  - Cycles after E+0..E+BEATS-1: `bram_en_out`=1, `bram_we_out`=1, `bram_addr_out`=base+k, `bram_din_out`=latched word slice k.
  - Edge E+BEATS: `bram_en_out`=`bram_we_out`=0, `finished_out`=1, state IDLE. `weight_out` is unaffected.
- IDLE drives `bram_en_out`=0, `bram_we_out`=0.
- Address arithmetic is unsigned, width $clog2(WEIGHT_LENGTH*BEATS).
- pointer ≥ WEIGHT_LENGTH (non-power-of-two sizes): no BRAM access. The operation completes with `finished_out`=1 at E+1; a read returns all zeros.
- Earliest back-to-back request: the edge after `finished_out` returns to 1.

Optional Feature:
- Macro: WEIGHT_MEDIUM_LAST_WORD_CACHE_EN.
- Defined: keep a one-entry cache of the last read or written word plus its pointer and a valid bit. Reset clears the valid bit.
  - A read hitting a valid entry makes no BRAM access; `weight_out` is loaded from the cache and `finished_out`=1 at E+1.
  - A write updates the cache and still performs the full BRAM write.
- Undefined: no cache; every read takes BEATS+READ_LATENCY cycles.

Test Plan:
- W_SIZE=16, BRAM_WIDTH=4, READ_LATENCY=2, pointer=3, write 16'hA5C3 -> `bram_addr_out` 12,13,14,15 with `bram_din_out` 3,C,5,A on consecutive cycles; `finished_out` 0 for 4 cycles, 1 at E+4.
- Then read pointer=3 (cache off) -> `finished_out` low 6 cycles, high at E+6 with `weight_out`=16'hA5C3.
- Read and write enables both high at E, pointer=1, `weight_in`=16'h1234 -> only write beats to addresses 4..7 with `bram_we_out`=1; a later read of pointer 1 returns 16'h1234.
- `read_enable_in` pulsed again at E+2 during a read -> ignored; exactly 4 BRAM read addresses issued; single completion.
- `rst_in`=0 at E+2 of a write -> next cycle `bram_we_out`=0, `finished_out`=1, `weight_out`=0; only beats 0–1 are written.
- With WEIGHT_MEDIUM_LAST_WORD_CACHE_EN: write pointer 7 = 16'hBEEF, then read pointer 7 -> `finished_out` high at E+1, `weight_out`=16'hBEEF, `bram_en_out` never asserted during the read.
